calc_display_ctrl: RTL and testbench
====================================

# calc_display_ctrl

Sequencing controller between the calculator's arithmetic result and the 8-digit `C7SEG` display decoder. It accepts a binary result over a valid/ready handshake and converts it to eight BCD digits with a sequential shift-add-3 (double-dabble) engine. It then applies leading-zero blanking and overflow handling, and updates the `num0`..`num7` digit registers that feed `C7SEG` atomically. The displayed value stays stable during a conversion.

## Interface
- `BIN_W`, 27: width of the unsigned magnitude input; must be ≥ 27 to cover 99_999_999.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: `in_value` is offered.
- `in_ready`  out  1: controller can accept; high only in IDLE.
- `in_value`  in  BIN_W: unsigned magnitude to display.
- `in_neg`  in  1: sign of `in_value`; ignored without `CALC_NEG_SIGN_EN`.
- `num0`..`num7`  out  4 each: digit codes to `C7SEG`; `num0` is the rightmost, least-significant digit.
- `done`  out  1: one-cycle pulse when new digits are written.
- `ovf`  out  1: sticky until the next accepted value; high if the last value was unrepresentable.

## Operation
- Digit codes: 0–9 are BCD, `4'hA` is MINUS, `4'hE` is ERR, and `4'hF` is BLANK (`C7SEG` renders MINUS as segment g only and BLANK as all segments off).
- FSM states and transitions:
  - IDLE: on `in_valid && in_ready`, capture `in_value`/`in_neg` and go to LOAD.
  - LOAD: range check, load the shift register, clear the BCD accumulator, set the counter to 0, go to SHIFT.
  - SHIFT: each cycle, add 3 to every BCD nibble ≥ 5, then shift the combined register left by 1 and increment the counter; after the BIN_W-th shift, go to FORMAT.
  - FORMAT: write `num0..7`, pulse `done`, go to IDLE.
- Overflow is detected in LOAD: the value is > 99_999_999, or, with `CALC_NEG_SIGN_EN`, it is negative and > 9_999_999.
  - On overflow, SHIFT is skipped: LOAD goes directly to FORMAT.
  - Output on overflow: `num0`=ERR, `num1..7`=BLANK, `ovf`=1.
- Leading-zero blanking: every digit above the most significant nonzero digit is BLANK. Value 0 shows `num0`=0 and all others BLANK.
- Negative sign (macro on): MINUS is placed in the digit immediately left of the most significant nonzero digit. Negative zero displays as plain 0 with no MINUS.
- `num*` registers change only at the FORMAT edge, never mid-conversion.
- `in_valid` while busy is not accepted; the source must hold it until `in_ready`.

## Timing
- Accept edge E0. LOAD edge E1, SHIFT edges E2..E(BIN_W+1), FORMAT edge E(BIN_W+2), which is E29 at the default width.
- `num*`, `ovf` and `done` are valid after E29; `done` is high for exactly one cycle.
- `in_ready` is high again after E29; a back-to-back accept is possible at E30.
- Overflow path: FORMAT at E2, with `done` following E2.
- Reset values: `num0`=0, `num1..7`=BLANK, `done`=0, `ovf`=0, `in_ready`=1, state IDLE, counter 0.
- Reset asserted mid-conversion aborts immediately to the reset values; no `done` is produced.

## Configuration
- `CALC_NEG_SIGN_EN` defined:
  - `in_neg` is honoured and MINUS placement is active.
  - The negative range is limited to 9_999_999; larger negatives are overflow.
- Undefined:
  - `in_neg` is ignored, and MINUS is never produced.
  - The overflow limit is 99_999_999 only.
  - The MINUS placement logic is not synthesised.

## Structure
- Package `calc_disp_pkg` holds:
  - digit codes `DIG_MINUS`, `DIG_ERR`, `DIG_BLANK`;
  - `NUM_DIGITS`=8, `MAX_POS`=99_999_999, `MAX_NEG`=9_999_999;
  - the state enum `{IDLE, LOAD, SHIFT, FORMAT}`.
- Sub-module `bcd_digit_adj`: combinational nibble add-3-if-≥5, instantiated 8×. Everything else is in `calc_display_ctrl`.

## Test plan
- Reset, then idle: `num0`=0, `num1..7`=F, `in_ready`=1, `done`=0. Assert `rst` at cycle 10 of a conversion of 12345 → outputs return to reset values and no `done`.
- Accept 12_345_678 → after 29 cycles, `num7..0` = 1,2,3,4,5,6,7,8, one `done` pulse, `ovf`=0; digits held at the old value before the pulse.
- Accept 5003 → `num3..0` = 5,0,0,3 and `num7..4`=F. Accept 0 → `num0`=0 and the rest F.
- Accept 100_000_000 → `done` 2 cycles after accept, `num0`=E, `num1..7`=F, `ovf`=1. The next valid value 7 clears `ovf`.
- With `CALC_NEG_SIGN_EN`:
  - −42 → `num2`=A, `num1`=4, `num0`=2, rest F.
  - −10_000_000 → overflow.
  - Without the macro, −42 shows 42.
- Hold `in_valid` with a second value 99 throughout a conversion of 1 → 99 is accepted only at the cycle after the first `done`, and is displayed 29 cycles later.

Source files
------------

// File: rtl/calc_disp_pkg.sv
// Shared digit codes, display limits and controller state encoding for calc_display_ctrl.
package calc_disp_pkg;

  localparam logic [3:0] DIG_MINUS = 4'hA;
  localparam logic [3:0] DIG_ERR   = 4'hE;
  localparam logic [3:0] DIG_BLANK = 4'hF;

  localparam int          NUM_DIGITS = 8;
  localparam int unsigned MAX_POS    = 99_999_999;
  localparam int unsigned MAX_NEG    = 9_999_999;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    FORMAT
  } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble correction cell: add 3 to a BCD nibble that is 5 or more.
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/calc_display_ctrl.sv
// Binary-to-8-digit display sequencer (double-dabble) with blanking and overflow.
// Optional macro CALC_NEG_SIGN_EN enables the sign input and MINUS placement.
module calc_display_ctrl
  import calc_disp_pkg::*;
#(
  parameter int BIN_W = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BIN_W-1:0] in_value,
  input  logic             in_neg,
  output logic [3:0]       num0,
  output logic [3:0]       num1,
  output logic [3:0]       num2,
  output logic [3:0]       num3,
  output logic [3:0]       num4,
  output logic [3:0]       num5,
  output logic [3:0]       num6,
  output logic [3:0]       num7,
  output logic             done,
  output logic             ovf
);

  localparam int               CNT_W     = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_SHFT = CNT_W'(BIN_W - 1);
  localparam logic [BIN_W-1:0] MAX_POS_W = BIN_W'(MAX_POS);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [BIN_W-1:0]  bin;
  logic [31:0]       bcd;
  logic [31:0]       bcd_adj;
  logic              ovf_det;
  logic              ovf_pend;
  logic [3:0]        disp [NUM_DIGITS];
  logic [3:0]        fmt  [NUM_DIGITS];
  logic [2:0]        msd;

`ifdef CALC_NEG_SIGN_EN
  localparam logic [BIN_W-1:0] MAX_NEG_W = BIN_W'(MAX_NEG);
  logic neg_r;
`else
  logic unused_neg;
  assign unused_neg = in_neg;
`endif

  assign in_ready = (state == IDLE);

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (bcd[4*g +: 4]),
      .dout (bcd_adj[4*g +: 4])
    );
  end

  always_comb begin
`ifdef CALC_NEG_SIGN_EN
    ovf_det = (bin > MAX_POS_W) || (neg_r && (bin > MAX_NEG_W));
`else
    ovf_det = (bin > MAX_POS_W);
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = LOAD;
      LOAD:    state_nxt = ovf_det ? FORMAT : SHIFT;
      SHIFT:   if (cnt == LAST_SHFT) state_nxt = FORMAT;
      FORMAT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Digit formatting from the finished BCD accumulator
  always_comb begin
    msd = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) msd = 3'(i);
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      fmt[i] = (3'(i) <= msd) ? bcd[4*i +: 4] : DIG_BLANK;
    end
`ifdef CALC_NEG_SIGN_EN
    if (neg_r && (bcd != 32'd0) && (msd != 3'd7)) fmt[msd + 3'd1] = DIG_MINUS;
`endif
    if (ovf_pend) begin
      for (int i = 0; i < NUM_DIGITS; i++) fmt[i] = DIG_BLANK;
      fmt[0] = DIG_ERR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      ovf_pend <= 1'b0;
`ifdef CALC_NEG_SIGN_EN
      neg_r    <= 1'b0;
`endif
      disp[0]  <= 4'd0;
      for (int i = 1; i < NUM_DIGITS; i++) disp[i] <= DIG_BLANK;
    end else begin
      state <= state_nxt;
      done  <= (state == FORMAT);
      case (state)
        IDLE: begin
          if (in_valid) begin
            ovf <= 1'b0;
`ifdef CALC_NEG_SIGN_EN
            neg_r <= in_neg;
`endif
          end
        end
        LOAD: begin
          cnt      <= '0;
          ovf_pend <= ovf_det;
        end
        SHIFT:   cnt <= cnt + 1'b1;
        FORMAT: begin
          ovf <= ovf_pend;
          for (int i = 0; i < NUM_DIGITS; i++) disp[i] <= fmt[i];
        end
        default: ;
      endcase
    end
  end

  // The shift register captures the operand directly at accept; LOAD clears the BCD half
  always_ff @(posedge clk) begin
    case (state)
      IDLE:    if (in_valid) bin <= in_value;
      LOAD:    bcd <= '0;
      SHIFT:   {bcd, bin} <= {bcd_adj[30:0], bin, 1'b0};
      default: ;
    endcase
  end

  assign num0 = disp[0];
  assign num1 = disp[1];
  assign num2 = disp[2];
  assign num3 = disp[3];
  assign num4 = disp[4];
  assign num5 = disp[5];
  assign num6 = disp[6];
  assign num7 = disp[7];

endmodule

// File: tb/tb_calc_display_ctrl.sv
// Randomized plus directed bench for calc_display_ctrl against a decimal reference model.
module tb_calc_display_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [26:0] in_value = '0;
  logic        in_neg = 1'b0;
  logic [3:0]  num0, num1, num2, num3, num4, num5, num6, num7;
  logic        done;
  logic        ovf;
  logic [31:0] nums;

  int checks   = 0;
  int failures = 0;
  logic [31:0] disp_exp;

  localparam logic [31:0] RESET_DISP = 32'hFFFF_FFF0;

  always #5 clk = ~clk;

  calc_display_ctrl #(.BIN_W(27)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_value (in_value),
    .in_neg   (in_neg),
    .num0     (num0),
    .num1     (num1),
    .num2     (num2),
    .num3     (num3),
    .num4     (num4),
    .num5     (num5),
    .num6     (num6),
    .num7     (num7),
    .done     (done),
    .ovf      (ovf)
  );

  assign nums = {num7, num6, num5, num4, num3, num2, num1, num0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Decimal reference: digits by repeated division, then blanking and sign
  function automatic void model(input logic [26:0] v, input logic n,
                                output logic [31:0] d, output logic o);
    logic neg_eff;
    int   x;
    int   k;
`ifdef CALC_NEG_SIGN_EN
    neg_eff = n;
`else
    neg_eff = 1'b0;
`endif
    o = (v > 27'd99_999_999) || (neg_eff && (v > 27'd9_999_999));
    d = 32'hFFFF_FFFF;
    if (o) begin
      d[3:0] = 4'hE;
    end else begin
      x = int'(v);
      k = 0;
      do begin
        d[4*k +: 4] = 4'(x % 10);
        x = x / 10;
        k++;
      end while (x > 0);
      if (neg_eff && (v != 0) && (k < 8)) d[4*k +: 4] = 4'hA;
    end
  endfunction

  task automatic wait_done(output int lat, output bit stable);
    lat = 0;
    stable = 1'b1;
    while (!done && lat < 100) begin
      if (nums !== disp_exp) stable = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_conv(input logic [26:0] v, input logic n);
    logic [31:0] exp_d;
    logic        exp_o;
    int          lat;
    bit          stable;
    model(v, n, exp_d, exp_o);
    check("ready_before", {31'd0, in_ready}, 32'd1);
    in_value = v;
    in_neg   = n;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(lat, stable);
    check("latency", lat, exp_o ? 32'd2 : 32'd29);
    check("held", {31'd0, stable}, 32'd1);
    check("digits", nums, exp_d);
    check("ovf", {31'd0, ovf}, {31'd0, exp_o});
    disp_exp = exp_d;
    @(posedge clk); #1;
    check("done_pulse", {31'd0, done}, 32'd0);
    check("ready_after", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int          lat;
    int          dcount;
    bit          stable;
    logic [31:0] exp_d;
    logic        exp_o;
    logic [26:0] rv;

    disp_exp = RESET_DISP;
    repeat (3) @(posedge clk);
    #1;
    check("rst_digits", nums, RESET_DISP);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_digits", nums, RESET_DISP);

    run_conv(27'd12_345_678, 1'b0);
    run_conv(27'd5003, 1'b0);
    run_conv(27'd0, 1'b0);
    run_conv(27'd100_000_000, 1'b0);
    run_conv(27'd7, 1'b0);
    run_conv(27'd99_999_999, 1'b0);
    run_conv(27'd42, 1'b1);
    run_conv(27'd10_000_000, 1'b1);
    run_conv(27'd9_999_999, 1'b1);
    run_conv(27'd0, 1'b1);
    run_conv(27'h7FF_FFFF, 1'b0);

    // Reset in the middle of a conversion
    in_value = 27'd12345;
    in_neg   = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_digits", nums, RESET_DISP);
    check("abort_ready", {31'd0, in_ready}, 32'd1);
    check("abort_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    disp_exp = RESET_DISP;
    dcount = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("abort_no_done", dcount, 32'd0);
    check("abort_hold", nums, RESET_DISP);

    // Held in_valid: second value is taken only after the first finishes
    in_value = 27'd1;
    in_neg   = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_value = 27'd99;
    wait_done(lat, stable);
    check("b2b_lat1", lat, 32'd29);
    check("b2b_dig1", nums, 32'hFFFF_FFF1);
    check("b2b_ready", {31'd0, in_ready}, 32'd1);
    disp_exp = 32'hFFFF_FFF1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(lat, stable);
    check("b2b_lat2", lat, 32'd29);
    check("b2b_held", {31'd0, stable}, 32'd1);
    check("b2b_dig2", nums, 32'hFFFF_FF99);
    disp_exp = 32'hFFFF_FF99;
    @(posedge clk); #1;

    // Random values across in-range, small and overflow regions
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0:       rv = 27'($urandom_range(0, 999));
        1:       rv = 27'($urandom_range(0, 99_999_999));
        2:       rv = 27'($urandom_range(9_000_000, 11_000_000));
        default: rv = 27'($urandom_range(99_000_000, 134_217_727));
      endcase
      run_conv(rv, 1'($urandom_range(0, 1)));
    end

    model(27'd3, 1'b0, exp_d, exp_o);
    run_conv(27'd3, 1'b0);
    check("final_digits", nums, exp_d);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
